// File: rtl/buf_ram_streamer_if.sv
// Byte stream handshake bundle: valid/ready with a last-beat marker.
// The master drives data and valid; the slave drives ready.
interface buf_ram_streamer_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/buf_ram_streamer.sv
// Streams LEN consecutive bytes from a 1-cycle-latency buffer RAM as a valid/ready
// byte stream, absorbing RAM latency and backpressure through a 2-entry output FIFO.
module buf_ram_streamer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    buf_ram_streamer_if.master m_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_last_q, head_last_d;
    logic              tail_valid_q, tail_valid_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic              tail_last_q, tail_last_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [1:0]        occupancy;

    assign pop       = head_valid_q & m_if.m_ready;
    assign push      = inflight_q;
    assign occupancy = {1'b0, head_valid_q} + {1'b0, tail_valid_q} + {1'b0, inflight_q};

    // A full pipeline (2 slots committed) may still issue when a beat leaves this cycle.
    assign issue = (state_q == RUN) && (remaining_q != '0) &&
                   ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

    // The RAM registers its address on the edge, so the issuing address goes out combinationally.
    assign ram_addr = issue ? addr_q : ram_addr_q;
    assign ram_wen  = 1'b0;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    assign m_if.m_valid = head_valid_q;
    assign m_if.m_data  = head_data_q;
    assign m_if.m_last  = head_last_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d         = state_q;
        addr_d          = addr_q;
        ram_addr_d      = ram_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = inflight_last_q;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = len;
                        addr_d      = start_addr;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    ram_addr_d      = addr_q;
                    addr_d          = addr_q + ADDR_ONE;
                    remaining_d     = remaining_q - LEN_ONE;
                    inflight_last_d = (remaining_q == LEN_ONE);
                    if (remaining_q == LEN_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (pop && head_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head entry is the registered stream output; tail only fills while the head is stalled.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        tail_valid_d = tail_valid_q;
        tail_data_d  = tail_data_q;
        tail_last_d  = tail_last_q;

        case ({push, pop})
            2'b01: begin
                head_valid_d = tail_valid_q;
                head_data_d  = tail_data_q;
                head_last_d  = tail_last_q;
                tail_valid_d = 1'b0;
            end
            2'b10: begin
                if (!head_valid_q) begin
                    head_valid_d = 1'b1;
                    head_data_d  = ram_rdata;
                    head_last_d  = inflight_last_q;
                end else begin
                    tail_valid_d = 1'b1;
                    tail_data_d  = ram_rdata;
                    tail_last_d  = inflight_last_q;
                end
            end
            2'b11: begin
                if (tail_valid_q) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = ram_rdata;
                    tail_last_d = inflight_last_q;
                end else begin
                    head_data_d = ram_rdata;
                    head_last_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            ram_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            head_valid_q    <= 1'b0;
            head_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_valid_q    <= 1'b0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            ram_addr_q      <= ram_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            head_valid_q    <= head_valid_d;
            head_data_q     <= head_data_d;
            head_last_q     <= head_last_d;
            tail_valid_q    <= tail_valid_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
        end
    end

endmodule

// File: tb/tb_buf_ram_streamer.sv
// Self-checking bench for buf_ram_streamer: queue-based stream model checked every cycle,
// plus directed commands with hand-computed timing and data expectations.
module tb_buf_ram_streamer;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;

    buf_ram_streamer_if #(.DATA_W(DATA_W)) s_if ();

    buf_ram_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_wen    (ram_wen),
        .ram_rdata  (ram_rdata),
        .m_if       (s_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [512];
    beat_t      exp_q[$];
    logic [7:0] seen_q[$];
    logic       m_busy;
    logic       m_done;
    logic       nxt_busy;
    logic       nxt_done;
    logic       stall_q;
    logic [7:0] prev_data;
    logic       prev_last;
    beat_t      e;
    logic [5:0] ready_pat = 6'b101001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data for the address seen at an edge appears after that edge.
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seen_at(input int idx);
        if (idx < seen_q.size()) return seen_q[idx];
        return 8'h00;
    endfunction

    function automatic logic [31:0] seen4();
        return {seen_at(0), seen_at(1), seen_at(2), seen_at(3)};
    endfunction

    // Stream model: an accepted command becomes a queue of expected beats; every handshake
    // must match the queue front, and the last beat's handshake ends the command with done.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            stall_q = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("ram_wen", ram_wen, 0);
            if (stall_q) begin
                check("stall_valid", s_if.m_valid, 1);
                check("stall_data", s_if.m_data, prev_data);
                check("stall_last", s_if.m_last, prev_last);
            end
            nxt_busy = m_busy;
            nxt_done = 1'b0;
            if (exp_q.size() == 0) begin
                check("spurious_valid", s_if.m_valid, 0);
            end else if (s_if.m_valid) begin
                check("beat_data", s_if.m_data, exp_q[0].d);
                check("beat_last", s_if.m_last, exp_q[0].l);
                if (s_if.m_ready) begin
                    e = exp_q.pop_front();
                    seen_q.push_back(s_if.m_data);
                    if (e.l) begin
                        nxt_busy = 1'b0;
                        nxt_done = 1'b1;
                    end
                end
            end
            if (!m_busy && start) begin
                if (len == 0) begin
                    nxt_done = 1'b1;
                end else begin
                    nxt_busy = 1'b1;
                    for (int i = 0; i < int'(len); i++) begin
                        exp_q.push_back('{d: mem[(int'(start_addr) + i) % 512], l: (i == int'(len) - 1)});
                    end
                end
            end
            stall_q   = s_if.m_valid && !s_if.m_ready;
            prev_data = s_if.m_data;
            prev_last = s_if.m_last;
            m_busy    = nxt_busy;
            m_done    = nxt_done;
        end
    end

    // Issue one command, then drive ready (constant or toggling) until the block is idle again.
    // An optional second start pulse with a different command is injected while busy.
    task automatic run_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n,
                           input bit toggle, input int inject_at);
        int k;
        bit finished;
        seen_q.delete();
        @(posedge clk); #1;
        start        = 1'b1;
        start_addr   = a;
        len          = n;
        s_if.m_ready = toggle ? ready_pat[0] : 1'b1;
        k        = 1;
        finished = 1'b0;
        while (!finished && k < 2000) begin
            @(posedge clk); #1;
            start        = (k == inject_at);
            start_addr   = 9'h080;
            len          = 10'd5;
            s_if.m_ready = toggle ? ready_pat[k % 6] : 1'b1;
            k++;
            if (!busy && !s_if.m_valid) finished = 1'b1;
        end
        start        = 1'b0;
        s_if.m_ready = 1'b1;
        check("cmd_completes", finished, 1);
        @(posedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    logic [6:0] vv, dd, bb, ll;
    logic [7:0] dat [7];
    int         beats;
    int         guard;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h010] = 8'hA0; mem[16'h011] = 8'hA1; mem[16'h012] = 8'hA2; mem[16'h013] = 8'hA3;
        mem[16'h1FE] = 8'h11; mem[16'h1FF] = 8'h22; mem[16'h000] = 8'h33; mem[16'h001] = 8'h44;
        mem[16'h050] = 8'hC1; mem[16'h051] = 8'hC2; mem[16'h052] = 8'hC3;
        ram_rdata    = '0;
        rst_n        = 1'b0;
        start        = 1'b0;
        start_addr   = '0;
        len          = '0;
        s_if.m_ready = 1'b1;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", s_if.m_valid, 0);
        check("rst_data", s_if.m_data, 0);
        check("rst_last", s_if.m_last, 0);
        check("rst_ram_addr", ram_addr, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Basic 4-byte read with hand-computed cycle timing.
        @(posedge clk); #1;
        start = 1'b1; start_addr = 9'h010; len = 10'd4; s_if.m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vv[i] = s_if.m_valid; dd[i] = done; bb[i] = busy; ll[i] = s_if.m_last; dat[i] = s_if.m_data;
        end
        check("t1_valid_timing", vv, 7'b0111100);
        check("t1_done_timing", dd, 7'b1000000);
        check("t1_busy_timing", bb, 7'b0111111);
        check("t1_last_timing", ll, 7'b0100000);
        check("t1_beats", {dat[2], dat[3], dat[4], dat[5]}, 32'hA0A1A2A3);

        // Same command under toggling backpressure.
        run_cmd(9'h010, 10'd4, 1'b1, -1);
        check("t2_toggle_beats", seen4(), 32'hA0A1A2A3);
        check("t2_toggle_count", seen_q.size(), 4);

        // Address wrap 0x1FE -> 0x001.
        run_cmd(9'h1FE, 10'd4, 1'b0, -1);
        check("t3_wrap_beats", seen4(), 32'h11223344);

        // Zero-length command: done pulse only.
        @(posedge clk); #1;
        start = 1'b1; start_addr = 9'h020; len = 10'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vv[i] = s_if.m_valid; dd[i] = done; bb[i] = busy;
        end
        check("t4_len0_done", dd[2:0], 3'b001);
        check("t4_len0_busy", bb[2:0], 3'b000);
        check("t4_len0_valid", vv[2:0], 3'b000);

        // Full-buffer read from 0x100 wrapping through 0x0FF.
        run_cmd(9'h100, 10'd512, 1'b0, -1);
        check("t5_full_count", seen_q.size(), 512);
        check("t5_full_first", seen_at(0), 8'h5A);
        check("t5_full_wrap", seen_at(256), 8'h33);
        check("t5_full_final", seen_at(511), 8'hA5);

        // Start pulsed again mid-transfer must be ignored.
        run_cmd(9'h020, 10'd6, 1'b1, 2);
        check("t6_ignore_count", seen_q.size(), 6);
        check("t6_ignore_first", seen_at(0), 8'h7A);

        // Asynchronous reset after beat 2 of 8.
        @(posedge clk); #1;
        start = 1'b1; start_addr = 9'h040; len = 10'd8; s_if.m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < 2 && guard < 50) begin
            @(negedge clk);
            if (s_if.m_valid && s_if.m_ready) beats++;
            guard++;
        end
        check("t7_two_beats_seen", beats, 2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", s_if.m_valid, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("t7_no_done_after_abort", done, 0);
        run_cmd(9'h050, 10'd3, 1'b0, -1);
        check("t7_post_reset_count", seen_q.size(), 3);
        check("t7_post_reset_beats", {seen_at(0), seen_at(1), seen_at(2)}, 24'hC1C2C3);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/buf_ram_streamer.md
Name: buf_ram_streamer

Overview:
- Read-side client for the 512x8 synchronous buffer RAM (1-cycle registered read, no read enable).
- On a start command it reads LEN consecutive bytes beginning at START_ADDR and emits them as a valid/ready byte stream, with the last beat flagged.
- Sits between the buffer RAM port and any downstream byte consumer (UART TX, SPI master, etc.).
- Absorbs RAM read latency and downstream backpressure without losing or duplicating bytes.

Parameters:
ADDR_W, 9, RAM address width; the RAM holds 2**ADDR_W bytes.
DATA_W, 8, RAM and stream data width.

Ports:
clk  input  1  system clock, all state on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled only while idle.
start_addr  input  ADDR_W  first RAM address to read.
len  input  ADDR_W+1  number of bytes, 0..512.
busy  output  1  high while a command is in progress.
done  output  1  one-cycle completion pulse.
ram_addr  output  ADDR_W  address to RAM.
ram_wen  output  1  RAM write enable, constant 0.
ram_rdata  input  DATA_W  RAM read data, valid one cycle after address.
m_valid  output  1  stream data valid.
m_data  output  DATA_W  stream byte.
m_last  output  1  marks final byte of command.
m_ready  input  1  downstream accepts byte when high with m_valid.

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, FIFO empty, in-flight flag cleared. Reset mid-command aborts it; no done pulse follows.
- ram_wen is tied 0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 and len!=0 at edge E0: latch remaining=len, next address=start_addr; go RUN; busy=1 after E0.
  - start=1 and len=0: busy stays 0; done=1 for the cycle after E0; no beats emitted.
  - start while busy is ignored.
- Issue (RUN):
  - Each cycle, a read is issued when remaining>0 and either (fifo_count + inflight) < 2, or that sum is 2 and a stream handshake occurs this cycle.
  - Issue registers ram_addr=current address, increments the address modulo 2**ADDR_W (wrap 511->0), decrements remaining, and sets inflight for next cycle.
  - When remaining reaches 0 after an issue, go FLUSH.
- Capture: one cycle after an issue, ram_rdata is pushed into a 2-entry output FIFO along with last = (it was the final issued address).
- Stream:
  - m_valid = FIFO non-empty; m_data and m_last are the head entry, registered outputs.
  - A pop occurs on m_valid && m_ready.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Latency: with m_ready held high, first m_valid is asserted in the cycle after edge E0+2. Throughput is then 1 byte/cycle, contiguous, with no bubbles.
- FIFO never overflows: the issue rule guarantees fifo_count + inflight <= 2 after every edge. Push and pop in the same cycle are allowed.
- FLUSH: on the handshake of the m_last beat, go IDLE, busy=0 after that edge, done=1 for exactly one cycle.
- A new start is accepted no earlier than the cycle done is high.
- len=512 with any start_addr reads every location exactly once, wrapping.
- ram_addr holds its last issued value while not issuing. The RAM re-reading that address is harmless because capture only follows an issue.

Test Plan:
- mem[0x10..0x13]=A0,A1,A2,A3; start_addr=0x10, len=4, m_ready=1 -> beats A0,A1,A2,A3 on 4 consecutive cycles, first m_valid 2 edges after start edge, m_last only on A3, done pulse 1 cycle after A3 handshake, busy low thereafter.
- Same command with m_ready toggling 1,0,0,1,0,1... -> exactly 4 beats in order, no duplication or loss; m_data/m_last stable during every stall; fifo_count never exceeds 2.
- start_addr=0x1FE, len=4 with mem[0x1FE]=11, mem[0x1FF]=22, mem[0x000]=33, mem[0x001]=44 -> stream 11,22,33,44 (address wrap).
- len=0 -> done pulses for 1 cycle, m_valid never asserted, busy stays 0. len=512 from addr 0x100 -> 512 beats matching mem[0x100..0x1FF], mem[0x000..0x0FF].
- start pulsed again mid-transfer (different addr) -> ignored; original stream completes unchanged.
- rst_n asserted low asynchronously mid-stream (after beat 2 of 8) -> m_valid, busy, done drop immediately. After release, a new command with len=3 streams correctly with no stale bytes.
